// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: client/RAM signal bundle for the framebuffer arbiter
//   slave  modport : arbiter side (vram_arbiter)
//   master modport : environment side (VGA reader, CPU, clear trigger, RAM)
//   vga_*  : VGA read strobe, address, captured data
//   cpu_*  : CPU req/ack access (we, addr, wdata, rdata)
//   clr_*  : clear-screen start pulse and busy flag
//   mem_*  : single RAM port (addr, we, wdata, synchronous rdata)
interface vram_arbiter_if;
    logic        vga_req;
    logic [11:0] vga_addr;
    logic [7:0]  vga_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        clr_start;
    logic        clr_busy;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    modport slave (
        input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, clr_start, mem_rdata,
        output vga_data, cpu_ack, cpu_rdata, clr_busy, mem_addr, mem_we, mem_wdata
    );
    modport master (
        output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, clr_start, mem_rdata,
        input  vga_data, cpu_ack, cpu_rdata, clr_busy, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port framebuffer RAM arbiter, grant priority VGA > clear > CPU
//   clk : system clock (posedge)
//   rst : asynchronous active-high reset
//   bus : vram_arbiter_if.slave -- VGA read strobe/data, CPU req/ack access,
//         clear-screen start/busy, RAM address/write enable/write data/read data
//   VRAM_CLEAR_EN : define to compile in the clear-screen sequencer
module vram_arbiter #(
    parameter logic [11:0] FB_BASE  = 12'hF00,
    parameter int          FB_BYTES = 256
) (
    input  logic          clk,
    input  logic          rst,
    vram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {CPU_IDLE, CPU_RD_WAIT, CPU_ACK} cpu_state_t;
    cpu_state_t  r_cpu_state, w_cpu_next;
    logic        r_vga_pend;
    logic [7:0]  r_vga_data, r_cpu_rdata;
    logic        w_clr_busy, w_clr_gnt, w_cpu_gnt;
    logic [11:0] w_clr_addr;
`ifdef VRAM_CLEAR_EN
    typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;
    localparam logic [7:0] CLR_LAST = 8'(FB_BYTES - 1);
    clr_state_t  r_clr_state, w_clr_next;
    logic [7:0]  r_clr_cnt, w_clr_cnt_next;
    logic        w_clr_done;
    assign w_clr_busy = r_clr_state == CLR_RUN;
    assign w_clr_addr = FB_BASE + {4'd0, r_clr_cnt};
    assign w_clr_done = w_clr_gnt && r_clr_cnt == CLR_LAST;
    always_comb begin
        w_clr_next     = r_clr_state == CLR_IDLE ? (bus.clr_start ? CLR_RUN : CLR_IDLE)
                                                 : (w_clr_done ? CLR_IDLE : CLR_RUN);
        w_clr_cnt_next = w_clr_done ? 8'd0 : w_clr_gnt ? r_clr_cnt + 8'd1 : r_clr_cnt;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr_state <= CLR_IDLE;
            r_clr_cnt   <= 8'd0;
        end else begin
            r_clr_state <= w_clr_next;
            r_clr_cnt   <= w_clr_cnt_next;
        end
    end
`else
    logic w_unused;
    assign w_clr_busy = 1'b0;
    assign w_clr_addr = 12'h000;
    assign w_unused   = &{1'b0, bus.clr_start, FB_BASE, 12'(FB_BYTES)};
`endif
    assign w_clr_gnt = w_clr_busy && !bus.vga_req;
    // IDLE implies cpu_ack is low, so the ack cycle never re-grants a held request
    assign w_cpu_gnt = bus.cpu_req && !bus.vga_req && !w_clr_busy && r_cpu_state == CPU_IDLE;
    always_comb begin
        bus.mem_addr  = bus.vga_req ? bus.vga_addr : w_clr_gnt ? w_clr_addr : w_cpu_gnt ? bus.cpu_addr : 12'h000;
        bus.mem_we    = w_clr_gnt || (w_cpu_gnt && bus.cpu_we);
        bus.mem_wdata = w_cpu_gnt ? bus.cpu_wdata : 8'h00;
    end
    always_comb begin
        w_cpu_next = r_cpu_state == CPU_IDLE    ? (w_cpu_gnt ? (bus.cpu_we ? CPU_ACK : CPU_RD_WAIT) : CPU_IDLE)
                   : r_cpu_state == CPU_RD_WAIT ? CPU_ACK : CPU_IDLE;
    end
    // Read data arrives one cycle after the address; each reader captures in its own
    // follow-up cycle, so a VGA grant during CPU RD_WAIT does not disturb the CPU read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cpu_state <= CPU_IDLE;
            r_vga_pend  <= 1'b0;
            r_vga_data  <= 8'h00;
            r_cpu_rdata <= 8'h00;
        end else begin
            r_cpu_state <= w_cpu_next;
            r_vga_pend  <= bus.vga_req;
            if (r_vga_pend) r_vga_data <= bus.mem_rdata;
            if (r_cpu_state == CPU_RD_WAIT) r_cpu_rdata <= bus.mem_rdata;
        end
    end
    assign bus.vga_data  = r_vga_data;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.cpu_ack   = r_cpu_state == CPU_ACK;
    assign bus.clr_busy  = w_clr_busy;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: self-checking bench for vram_arbiter with a behavioural RAM and reference model
`timescale 1ns/1ps
module tb_vram_arbiter;
    localparam logic [11:0] FB_BASE  = 12'hF00;
    localparam int          FB_BYTES = 256;
`ifdef VRAM_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic ram_init = 1'b0;
    int   init_mode = 0;
    logic [7:0] ram [0:4095];
    logic [7:0] ref_mem [0:4095];

    vram_arbiter_if bus();
    vram_arbiter #(.FB_BASE(FB_BASE), .FB_BYTES(FB_BYTES)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int mode, input int a);
        logic [11:0] aa;
        aa = 12'(a);
        init_val = (mode == 1 && aa >= FB_BASE) ? 8'hFF : (aa[7:0] ^ 8'hA0);
    endfunction

    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
        if (ram_init) for (int i = 0; i < 4096; i++) ram[i] <= init_val(init_mode, i);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        bus.vga_req = 1'b0; bus.vga_addr = 12'h000;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h000; bus.cpu_wdata = 8'h00;
        bus.clr_start = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic load(input int mode);
        init_mode = mode;
        ram_init = 1'b1;
        tick();
        ram_init = 1'b0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(mode, i);
    endtask

    task automatic vga_read(input logic [11:0] a, output logic [7:0] d);
        bus.vga_req = 1'b1; bus.vga_addr = a;
        tick();
        bus.vga_req = 1'b0;
        tick();
        d = bus.vga_data;
    endtask

    task automatic test_reset();
        idle();
        #1 rst = 1'b1;
        #2;
        checks++;
        if ({bus.cpu_ack, bus.clr_busy, bus.vga_data, bus.cpu_rdata, bus.mem_addr, bus.mem_we, bus.mem_wdata} !== 38'd0) begin
            failures++;
            $display("FAIL reset_outputs got ack=%b busy=%b vga=%h rd=%h addr=%h we=%b wd=%h exp all zero",
                     bus.cpu_ack, bus.clr_busy, bus.vga_data, bus.cpu_rdata, bus.mem_addr, bus.mem_we, bus.mem_wdata);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({bus.cpu_ack, bus.clr_busy} !== 2'b00) begin
            failures++;
            $display("FAIL reset_release got ack=%b busy=%b exp 0 0", bus.cpu_ack, bus.clr_busy);
        end
    endtask

    task automatic test_vga_read();
        load(0);
        bus.vga_req = 1'b1; bus.vga_addr = 12'hF05;
        #1;
        checks++;
        if ({bus.mem_addr, bus.mem_we} !== {12'hF05, 1'b0}) begin
            failures++;
            $display("FAIL vga_grant got addr=%h we=%b exp F05 0", bus.mem_addr, bus.mem_we);
        end
        tick();
        bus.vga_req = 1'b0;
        checks++;
        if (bus.vga_data !== 8'h00) begin
            failures++;
            $display("FAIL vga_early got=%h exp=00", bus.vga_data);
        end
        tick();
        checks++;
        if (bus.vga_data !== 8'hA5) begin
            failures++;
            $display("FAIL vga_data got=%h exp=A5", bus.vga_data);
        end
    endtask

    task automatic test_cpu_write_read();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 12'hF10; bus.cpu_wdata = 8'h3C;
        #1;
        checks++;
        if ({bus.mem_addr, bus.mem_we, bus.mem_wdata} !== {12'hF10, 1'b1, 8'h3C}) begin
            failures++;
            $display("FAIL cpu_wr_grant got addr=%h we=%b wd=%h exp F10 1 3C", bus.mem_addr, bus.mem_we, bus.mem_wdata);
        end
        tick();
        checks++;
        if (bus.cpu_ack !== 1'b1) begin
            failures++;
            $display("FAIL cpu_wr_ack got=%b exp=1", bus.cpu_ack);
        end
        bus.cpu_req = 1'b0;
        ref_mem[12'hF10] = 8'h3C;
        tick();
        checks++;
        if (bus.cpu_ack !== 1'b0) begin
            failures++;
            $display("FAIL cpu_wr_ack_pulse got=%b exp=0", bus.cpu_ack);
        end
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'hF10; bus.cpu_wdata = 8'h00;
        #1;
        checks++;
        if ({bus.mem_addr, bus.mem_we} !== {12'hF10, 1'b0}) begin
            failures++;
            $display("FAIL cpu_rd_grant got addr=%h we=%b exp F10 0", bus.mem_addr, bus.mem_we);
        end
        tick();
        checks++;
        if (bus.cpu_ack !== 1'b0) begin
            failures++;
            $display("FAIL cpu_rd_wait_ack got=%b exp=0", bus.cpu_ack);
        end
        tick();
        checks++;
        if ({bus.cpu_ack, bus.cpu_rdata} !== {1'b1, 8'h3C}) begin
            failures++;
            $display("FAIL cpu_rd_ack got ack=%b rd=%h exp 1 3C", bus.cpu_ack, bus.cpu_rdata);
        end
        bus.cpu_req = 1'b0;
        tick();
        checks++;
        if ({bus.cpu_ack, bus.cpu_rdata} !== {1'b0, 8'h3C}) begin
            failures++;
            $display("FAIL cpu_rd_hold got ack=%b rd=%h exp 0 3C", bus.cpu_ack, bus.cpu_rdata);
        end
    endtask

    task automatic test_vga_cpu_conflict();
        bus.vga_req = 1'b1; bus.vga_addr = 12'hF20;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'hF00; bus.cpu_wdata = 8'h00;
        #1;
        checks++;
        if ({bus.mem_addr, bus.mem_we} !== {12'hF20, 1'b0}) begin
            failures++;
            $display("FAIL conflict_vga_first got addr=%h we=%b exp F20 0", bus.mem_addr, bus.mem_we);
        end
        tick();
        bus.vga_req = 1'b0;
        #1;
        checks++;
        if (bus.mem_addr !== 12'hF00) begin
            failures++;
            $display("FAIL conflict_cpu_next got addr=%h exp F00", bus.mem_addr);
        end
        tick();
        checks++;
        if ({bus.cpu_ack, bus.vga_data} !== {1'b0, ref_mem[12'hF20]}) begin
            failures++;
            $display("FAIL conflict_mid got ack=%b vga=%h exp 0 %h", bus.cpu_ack, bus.vga_data, ref_mem[12'hF20]);
        end
        tick();
        checks++;
        if ({bus.cpu_ack, bus.cpu_rdata} !== {1'b1, ref_mem[12'hF00]}) begin
            failures++;
            $display("FAIL conflict_ack got ack=%b rd=%h exp 1 %h", bus.cpu_ack, bus.cpu_rdata, ref_mem[12'hF00]);
        end
        bus.cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_clear_full();
        int n;
        logic [7:0] d;
        do_reset();
        load(1);
        bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        n = 0;
        while (bus.clr_busy === 1'b1 && n < 2 * FB_BYTES) begin
            n++;
            tick();
        end
        checks++;
        if (n != FB_BYTES * int'(CLR_EN)) begin
            failures++;
            $display("FAIL clear_busy_len got=%0d exp=%0d", n, FB_BYTES * int'(CLR_EN));
        end
        if (CLR_EN) for (int i = 0; i < FB_BYTES; i++) ref_mem[FB_BASE + 12'(i)] = 8'h00;
        for (int a = 'hEFF; a <= 'hFFF; a++) begin
            vga_read(12'(a), d);
            checks++;
            if (d !== ref_mem[a]) begin
                failures++;
                $display("FAIL clear_content addr=%h got=%h exp=%h", 12'(a), d, ref_mem[a]);
            end
        end
    endtask

    task automatic test_clear_traffic();
        int left, ack_at;
        bit pend, ex_busy, vga;
        int vq_cyc[$];
        logic [7:0] vq_dat[$];
        logic [7:0] d;
        do_reset();
        load(1);
        bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 12'hF40; bus.cpu_wdata = 8'h99;
        left = CLR_EN ? FB_BYTES : 0;
        pend = 1'b1;
        ack_at = -1;
        for (int t = 0; t < 400; t++) begin
            ex_busy = left > 0;
            checks++;
            if (bus.clr_busy !== ex_busy) begin
                failures++;
                $display("FAIL traffic_busy cyc=%0d got=%b exp=%b", cyc, bus.clr_busy, ex_busy);
            end
            checks++;
            if (bus.cpu_ack !== (cyc == ack_at)) begin
                failures++;
                $display("FAIL traffic_ack cyc=%0d got=%b exp=%b", cyc, bus.cpu_ack, cyc == ack_at);
            end
            if (cyc == ack_at) bus.cpu_req = 1'b0;
            if (vq_cyc.size() > 0 && vq_cyc[0] == cyc) begin
                checks++;
                if (bus.vga_data !== vq_dat[0]) begin
                    failures++;
                    $display("FAIL traffic_vga cyc=%0d got=%h exp=%h", cyc, bus.vga_data, vq_dat[0]);
                end
                void'(vq_cyc.pop_front());
                void'(vq_dat.pop_front());
            end
            vga = (t % 4) == 0;
            bus.vga_req = vga;
            bus.vga_addr = 12'h100 + 12'(t);
            if (vga) begin
                vq_cyc.push_back(cyc + 2);
                vq_dat.push_back(ref_mem[12'h100 + 12'(t)]);
            end else if (ex_busy) begin
                ref_mem[FB_BASE + 12'(FB_BYTES - left)] = 8'h00;
                left--;
            end else if (pend) begin
                pend = 1'b0;
                ack_at = cyc + 1;
                ref_mem[12'hF40] = 8'h99;
            end
            tick();
        end
        bus.vga_req = 1'b0;
        for (int a = 'hF3F; a <= 'hF41; a++) begin
            vga_read(12'(a), d);
            checks++;
            if (d !== ref_mem[a]) begin
                failures++;
                $display("FAIL traffic_content addr=%h got=%h exp=%h", 12'(a), d, ref_mem[a]);
            end
        end
    endtask

    task automatic test_random();
        int clr_left, ack_at;
        bit active, pend, cur_we, vga, last_vga, busy, acked;
        logic [11:0] ca, va, ex_a;
        logic [7:0] cwd, ex_rd, ex_wd;
        logic ex_we;
        int vq_cyc[$];
        logic [7:0] vq_dat[$];
        do_reset();
        load(0);
        clr_left = 0; ack_at = -1; active = 0; pend = 0; last_vga = 0; cur_we = 0;
        ca = 0; cwd = 0; ex_rd = 0;
        for (int t = 0; t < 1500; t++) begin
            checks++;
            if (bus.clr_busy !== (clr_left > 0)) begin
                failures++;
                $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, bus.clr_busy, clr_left > 0);
            end
            acked = cyc == ack_at;
            checks++;
            if (bus.cpu_ack !== acked) begin
                failures++;
                $display("FAIL rand_ack cyc=%0d got=%b exp=%b", cyc, bus.cpu_ack, acked);
            end
            if (acked) begin
                if (!cur_we) begin
                    checks++;
                    if (bus.cpu_rdata !== ex_rd) begin
                        failures++;
                        $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", cyc, bus.cpu_rdata, ex_rd);
                    end
                end
                active = 0;
                bus.cpu_req = 1'b0;
            end
            if (vq_cyc.size() > 0 && vq_cyc[0] == cyc) begin
                checks++;
                if (bus.vga_data !== vq_dat[0]) begin
                    failures++;
                    $display("FAIL rand_vga cyc=%0d got=%h exp=%h", cyc, bus.vga_data, vq_dat[0]);
                end
                void'(vq_cyc.pop_front());
                void'(vq_dat.pop_front());
            end
            vga = !last_vga && $urandom_range(0, 2) == 0;
            last_vga = vga;
            va = FB_BASE + 12'($urandom_range(0, 31));
            bus.vga_req = vga;
            bus.vga_addr = va;
            bus.clr_start = $urandom_range(0, 599) == 0;
            if (!active && !acked && $urandom_range(0, 3) == 0) begin
                active = 1; pend = 1;
                cur_we = $urandom_range(0, 1) == 1;
                ca = FB_BASE + 12'($urandom_range(0, 31));
                cwd = 8'($urandom);
                bus.cpu_req = 1'b1; bus.cpu_we = cur_we; bus.cpu_addr = ca; bus.cpu_wdata = cwd;
            end
            busy = clr_left > 0;
            ex_a = 12'h000; ex_we = 1'b0; ex_wd = 8'h00;
            if (vga) begin
                ex_a = va;
                vq_cyc.push_back(cyc + 2);
                vq_dat.push_back(ref_mem[va]);
            end else if (busy) begin
                ex_a = FB_BASE + 12'(FB_BYTES - clr_left);
                ex_we = 1'b1;
                ref_mem[ex_a] = 8'h00;
                clr_left--;
            end else if (pend) begin
                pend = 0;
                ex_a = ca; ex_we = cur_we; ex_wd = cwd;
                if (cur_we) begin
                    ref_mem[ca] = cwd;
                    ack_at = cyc + 1;
                end else begin
                    ex_rd = ref_mem[ca];
                    ack_at = cyc + 2;
                end
            end
            if (CLR_EN && !busy && bus.clr_start) clr_left = FB_BYTES;
            #1;
            checks++;
            if ({bus.mem_addr, bus.mem_we, bus.mem_wdata} !== {ex_a, ex_we, ex_wd}) begin
                failures++;
                $display("FAIL rand_port cyc=%0d got addr=%h we=%b wd=%h exp addr=%h we=%b wd=%h",
                         cyc, bus.mem_addr, bus.mem_we, bus.mem_wdata, ex_a, ex_we, ex_wd);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.clr_start = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'hF05; bus.cpu_wdata = 8'h00;
        tick();
        bus.clr_start = 1'b0;
        checks++;
        if ({bus.clr_busy, bus.cpu_ack} !== {CLR_EN, 1'b0}) begin
            failures++;
            $display("FAIL rstmid_before got busy=%b ack=%b exp %b 0", bus.clr_busy, bus.cpu_ack, CLR_EN);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.clr_busy, bus.cpu_ack, bus.cpu_rdata} !== 10'd0) begin
            failures++;
            $display("FAIL rstmid_drop got busy=%b ack=%b rd=%h exp 0 0 00", bus.clr_busy, bus.cpu_ack, bus.cpu_rdata);
        end
        bus.cpu_req = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int t = 0; t < 6; t++) begin
            tick();
            checks++;
            if ({bus.clr_busy, bus.cpu_ack} !== 2'b00) begin
                failures++;
                $display("FAIL rstmid_after cyc=%0d got busy=%b ack=%b exp 0 0", cyc, bus.clr_busy, bus.cpu_ack);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vga_read();
        test_cpu_write_read();
        test_vga_cpu_conflict();
        test_clear_full();
        test_clear_traffic();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog cyc=%0d exp completion before timeout", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port framebuffer RAM arbiter for the CHIP-8 display path. Shares one synchronous-read RAM port between the VGA scanout reader, the CPU/draw engine (read/write with req/ack handshake) and an optional hardware clear-screen sequencer. It sits between the VGA timing block, the instruction executor and the memory block.

## Interface
- FB_BASE, 12'hF00, first framebuffer byte address
- FB_BYTES, 256, framebuffer size in bytes (64x32 pixels, 1 bpp); range 1..256
- clk  in  1  system clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- vga_req  in  1  VGA read request for this cycle (single-cycle strobe, no ack)
- vga_addr  in  12  VGA read address, valid with vga_req
- vga_data  out  8  last VGA read result
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  12  CPU address; stable while cpu_req
- cpu_wdata  in  8  CPU write data; stable while cpu_req
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  CPU read data, valid while cpu_ack high, held after
- clr_start  in  1  clear-screen start pulse
- clr_busy  out  1  clear sequence in progress
- mem_addr  out  12  RAM address (combinational from current grant)
- mem_we  out  1  RAM write enable
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM read data, valid the cycle after address presented

## Operation
- Per-cycle grant priority: VGA > clear > CPU. Exactly one grant or none per cycle.
- No grant: mem_addr = 0, mem_we = 0, mem_wdata = 0.
- VGA grant: mem_addr = vga_addr, mem_we = 0. Pipelined; vga_req may be high every cycle.
- Clear grant (clr_busy high, vga_req low): mem_addr = FB_BASE + clr_cnt, mem_we = 1, mem_wdata = 0; clr_cnt increments.
- CPU grant (cpu_req high, no VGA/clear grant, CPU idle, cpu_ack low): mem_addr = cpu_addr, mem_we = cpu_we, mem_wdata = cpu_wdata.
- CPU FSM: IDLE -> (grant, we=1) ACK -> IDLE; IDLE -> (grant, we=0) RD_WAIT -> ACK -> IDLE. cpu_req ignored outside IDLE and in the ACK cycle.
- Clear FSM: IDLE -> (clr_start) RUN -> (clr_cnt == FB_BYTES-1 written) IDLE. clr_start while RUN ignored. CPU requests stall during RUN; a pending CPU request is granted after clear completes.
- In-flight reads do not occupy the port; a VGA or clear grant may occur while a CPU read is in RD_WAIT.
- Arbitration is not fair to CPU: bounded CPU latency only if vga_req is never high on two consecutive cycles (guaranteed by the VGA pixel tick at 1/4 clk).

## Timing
- Reset: vga_data, cpu_rdata = 8'h00; cpu_ack, clr_busy = 0; FSMs IDLE; clr_cnt = 0; in-flight reads discarded. Reset mid-clear leaves framebuffer partially cleared.
- VGA read granted cycle N: vga_data updated at end of N+1, valid from N+2 until next VGA capture.
- CPU write granted cycle N: RAM written at end of N; cpu_ack high in N+1.
- CPU read granted cycle N: cpu_rdata captured at end of N+1; cpu_ack high in N+2.
- Same-cycle VGA and CPU requests: VGA granted in N, CPU in first later eligible cycle.
- clr_start in cycle N: clr_busy high from N+1; first write in N+1 if vga_req low; clr_busy low the cycle after the final write. Without VGA traffic clr_busy is high exactly FB_BYTES cycles.
- Write followed by read of same address on a later cycle returns new data (RAM is write-first across cycles; no same-cycle read/write occurs).

## Configuration
- VRAM_CLEAR_EN defined: clear sequencer, clr_cnt and clear FSM compiled in as above.
- VRAM_CLEAR_EN undefined: clr_start ignored, clr_busy tied 0, no clear grants; priority reduces to VGA > CPU.

## Test plan
- After rst: all outputs 0; VGA read of addr 12'hF05 (RAM holds 8'hA5) -> vga_data = 8'hA5 two cycles after request.
- CPU write 8'h3C to 12'hF10, then CPU read 12'hF10 -> write ack one cycle after grant, read ack two cycles after grant with cpu_rdata = 8'h3C.
- vga_req and cpu_req (read 12'hF00) asserted same cycle -> mem_addr = vga_addr that cycle, CPU granted next cycle, cpu_ack three cycles after request.
- clr_start with RAM pre-filled 8'hFF, no VGA traffic -> clr_busy high 256 cycles, all 12'hF00..12'hFFF read 8'h00, 12'hEFF unchanged.
- clr_start with vga_req every 4th cycle and a CPU write pending -> no VGA read lost, clear completes in 256 + skipped cycles, CPU write acked only after clr_busy falls.
- rst asserted mid-clear and during CPU RD_WAIT -> clr_busy, cpu_ack drop to 0 immediately; no ack after reset release.
